// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// The producer drives data/valid; the transmitter answers with ready.
interface uart_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, even parity, one stop bit.
// A one-entry holding register lets the next byte queue up so frames run back to back.
module uart_tx #(
   parameter int CNT_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] clks_per_bit,
   uart_tx_if.slave         bus,
   output logic             TX_out,
   output logic             tx_busy,
   output logic             tx_done
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t           state;
   logic [7:0]       hold_data;
   logic             hold_full;
   logic [7:0]       shift;
   logic             parity;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] period;
   logic [2:0]       bit_idx;
   logic             bit_end;
   logic             load;

   assign bus.tx_ready = ~hold_full;
   assign bit_end      = (cnt == period);

   // A held byte is loaded when idle or exactly at the end of a stop bit, so frames abut.
   assign load = hold_full && ((state == IDLE) || (state == STOP && bit_end));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         hold_data <= '0;
         hold_full <= 1'b0;
         shift     <= '0;
         parity    <= 1'b0;
         cnt       <= '0;
         period    <= '0;
         bit_idx   <= '0;
         TX_out    <= 1'b1;
         tx_busy   <= 1'b0;
         tx_done   <= 1'b0;
      end else begin
         tx_done <= 1'b0;

         if (bus.tx_valid && !hold_full) begin
            hold_data <= bus.tx_data;
            hold_full <= 1'b1;
         end

         if (load) begin
            shift     <= hold_data;
            parity    <= ^hold_data;
            period    <= clks_per_bit;
            hold_full <= 1'b0;
            cnt       <= '0;
            bit_idx   <= '0;
            state     <= START;
            TX_out    <= 1'b0;
            tx_busy   <= 1'b1;
            if (state == STOP)
               tx_done <= 1'b1;
         end else if (state == IDLE) begin
            TX_out  <= 1'b1;
            tx_busy <= 1'b0;
            cnt     <= '0;
         end else if (!bit_end) begin
            cnt <= cnt + CNT_W'(1);
         end else begin
            cnt <= '0;
            case (state)
               START: begin
                  state   <= DATA;
                  bit_idx <= '0;
                  TX_out  <= shift[0];
               end
               DATA: begin
                  if (bit_idx == 3'd7) begin
                     state  <= PARITY;
                     TX_out <= parity;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shift   <= shift >> 1;
                     TX_out  <= shift[1];
                  end
               end
               PARITY: begin
                  state  <= STOP;
                  TX_out <= 1'b1;
               end
               STOP: begin
                  state   <= IDLE;
                  TX_out  <= 1'b1;
                  tx_busy <= 1'b0;
                  tx_done <= 1'b1;
               end
               default: begin
                  state  <= IDLE;
                  TX_out <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: accepted bytes are queued with their expected bit period
// and a line monitor decodes every frame cycle by cycle against them.
module tb_uart_tx;

   localparam int CNT_W = 10;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [CNT_W-1:0] clks_per_bit = CNT_W'(3);
   logic             TX_out;
   logic             tx_busy;
   logic             tx_done;

   uart_tx_if bus ();

   uart_tx #(.CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .clks_per_bit (clks_per_bit),
      .bus          (bus),
      .TX_out       (TX_out),
      .tx_busy      (tx_busy),
      .tx_done      (tx_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      int         p;
   } exp_t;

   exp_t sb[$];
   int   start_q[$];
   int   done_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   frames_done = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk)
      if (tx_done === 1'b1) done_q.push_back(cyc);

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Decodes one frame starting at the current negedge; a reset seen on the line abandons it.
   task automatic run_frame();
      exp_t        e;
      logic [10:0] bits;
      logic        first;
      logic        unstable;
      bit          aborted;
      aborted = 1'b0;
      first   = 1'b0;
      start_q.push_back(cyc);
      check_output("busy_at_start", 32'(tx_busy), 32'(1));
      if (sb.size() == 0) begin
         check_output("unexpected_frame", 32'(1), 32'(0));
         @(negedge clk);
         return;
      end
      e    = sb.pop_front();
      bits = {1'b1, ^e.data, e.data, 1'b0};
      for (int b = 0; b < 11 && !aborted; b++) begin
         unstable = 1'b0;
         for (int c = 0; c <= e.p; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst) begin
               aborted = 1'b1;
               break;
            end
            if (c == 0) first = TX_out;
            else if (TX_out !== first) unstable = 1'b1;
         end
         if (!aborted) begin
            check_output($sformatf("bit%0d_of_%02h", b, e.data), 32'(first), 32'(bits[b]));
            check_output($sformatf("bit%0d_stable", b), 32'(unstable), 32'(0));
         end
      end
      if (aborted) return;
      @(negedge clk);
      if (!rst) begin
         check_output("done_pulse", 32'(tx_done), 32'(1));
         frames_done++;
      end
   endtask

   initial begin : monitor
      @(negedge clk);
      forever begin
         if (rst !== 1'b0 || TX_out !== 1'b0) @(negedge clk);
         else run_frame();
      end
   end

   task automatic apply_stimulus(input logic [7:0] d, input int p, output int hs);
      exp_t e;
      hs = -1;
      bus.tx_data  = d;
      bus.tx_valid = 1'b1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (bus.tx_ready === 1'b1) begin
            hs     = cyc;
            e.data = d;
            e.p    = p;
            sb.push_back(e);
            break;
         end
      end
      if (hs < 0) check_output("accept_timeout", 32'(0), 32'(1));
      @(posedge clk);
      #1;
      bus.tx_valid = 1'b0;
   endtask

   task automatic wait_frames(input int n);
      for (int i = 0; i < 3000 && frames_done < n; i++) begin
         @(negedge clk);
         #1;
      end
      check_output("frame_wait_timeout", 32'(frames_done >= n), 32'(1));
   endtask

   int hs1, hs2, n0, d0, lows, dones;

   initial begin : driver
      bus.tx_data  = 8'h77;
      bus.tx_valid = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_output("rst_tx_out", 32'(TX_out), 32'(1));
      check_output("rst_ready", 32'(bus.tx_ready), 32'(1));
      check_output("rst_busy", 32'(tx_busy), 32'(0));
      check_output("rst_done", 32'(tx_done), 32'(0));
      @(posedge clk);
      #1;
      rst          = 1'b0;
      bus.tx_valid = 1'b0;
      repeat (5) @(negedge clk);
      check_output("idle_after_rst_handshake", 32'(TX_out), 32'(1));
      check_output("ready_after_rst_handshake", 32'(bus.tx_ready), 32'(1));

      // Single frames from idle: latency, length, and post-frame state.
      @(posedge clk);
      #1;
      apply_stimulus(8'hA5, 3, hs1);
      wait_frames(1);
      check_output("a5_latency", 32'(start_q[0] - hs1), 32'(2));
      check_output("a5_length", 32'(done_q[done_q.size()-1] - start_q[0]), 32'(44));
      check_output("a5_busy_after", 32'(tx_busy), 32'(0));
      check_output("a5_ready_after", 32'(bus.tx_ready), 32'(1));
      @(negedge clk);
      check_output("a5_done_one_pulse", 32'(tx_done), 32'(0));

      @(posedge clk);
      #1;
      apply_stimulus(8'h01, 3, hs1);
      wait_frames(2);
      check_output("x01_latency", 32'(start_q[1] - hs1), 32'(2));
      check_output("x01_length", 32'(done_q[done_q.size()-1] - start_q[1]), 32'(44));

      // Back-to-back frames with the second byte queued during the first.
      @(posedge clk);
      #1;
      n0 = start_q.size();
      apply_stimulus(8'h55, 3, hs1);
      apply_stimulus(8'hFF, 3, hs2);
      check_output("b2b_second_accept", 32'(hs2 - hs1), 32'(2));
      wait_frames(4);
      check_output("b2b_start_gap", 32'(start_q[n0+1] - start_q[n0]), 32'(44));
      d0 = done_q.size();
      check_output("b2b_done_gap", 32'(done_q[d0-1] - done_q[d0-2]), 32'(44));
      check_output("b2b_total", 32'(done_q[d0-1] - start_q[n0]), 32'(88));

      // A period change mid-frame only affects the following frame.
      @(posedge clk);
      #1;
      n0 = start_q.size();
      apply_stimulus(8'hC3, 3, hs1);
      apply_stimulus(8'h3C, 7, hs2);
      repeat (8) @(posedge clk);
      #1;
      clks_per_bit = CNT_W'(7);
      wait_frames(6);
      check_output("cpb_first_len", 32'(start_q[n0+1] - start_q[n0]), 32'(44));
      check_output("cpb_second_len", 32'(done_q[done_q.size()-1] - start_q[n0+1]), 32'(88));

      // Minimum period.
      @(posedge clk);
      #1;
      clks_per_bit = CNT_W'(0);
      n0 = start_q.size();
      apply_stimulus(8'hFF, 0, hs1);
      wait_frames(7);
      check_output("cpb0_length", 32'(done_q[done_q.size()-1] - start_q[n0]), 32'(11));

      // Reset during DATA with a byte held: frame aborted, held byte dropped.
      @(posedge clk);
      #1;
      clks_per_bit = CNT_W'(3);
      apply_stimulus(8'hA5, 3, hs1);
      apply_stimulus(8'h3C, 3, hs2);
      repeat (10) @(posedge clk);
      #1;
      d0 = done_q.size();
      sb.delete();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_output("midrst_tx_out", 32'(TX_out), 32'(1));
      check_output("midrst_ready", 32'(bus.tx_ready), 32'(1));
      check_output("midrst_busy", 32'(tx_busy), 32'(0));
      lows  = 0;
      dones = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (TX_out !== 1'b1) lows++;
         if (tx_done !== 1'b0) dones++;
      end
      check_output("midrst_line_idle", 32'(lows), 32'(0));
      check_output("midrst_no_done", 32'(dones), 32'(0));
      check_output("midrst_done_count", 32'(done_q.size() - d0), 32'(0));

      check_output("scoreboard_empty", 32'(sb.size()), 32'(0));
      check_output("done_pulse_total", 32'(done_q.size()), 32'(frames_done));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
